// File: rtl/card_pkg.sv
// Shared constants and state encoding for the card dealer.
package card_pkg;

   localparam int CARD_W           = 4;
   localparam int CARD_MAX_DEFAULT = 13;

   localparam logic [CARD_W-1:0] NO_CARD = '0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SPIN  = 2'd1,
      CHECK = 2'd2
   } state_t;

endpackage

// File: rtl/card_dealer.sv
// Draws playing-card ranks from an LFSR word by rejection sampling.
// Optional macro CARD_NO_REPEAT_EN: reject a candidate equal to the current card.
module card_dealer
   import card_pkg::*;
#(
   parameter int N        = 8,
   parameter int CARD_MAX = CARD_MAX_DEFAULT,
   parameter int SPIN_MIN = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              draw_req,
   input  logic [N-1:0]      rand_in,
   output logic              rand_en,
   output logic              busy,
   output logic [CARD_W-1:0] card,
   output logic [CARD_W-1:0] prev_card,
   output logic              has_prev,
   output logic              card_valid,
   output logic              cmp_higher,
   output logic              cmp_equal
);

   localparam int CNT_W = (SPIN_MIN > 1) ? $clog2(SPIN_MIN) : 1;
   localparam logic [CNT_W-1:0]  LAST_SPIN = CNT_W'(SPIN_MIN - 1);
   localparam logic [CARD_W-1:0] MAX_RANK  = CARD_W'(CARD_MAX);

   state_t             state;
   logic [CNT_W-1:0]   spin_cnt;
   logic [CARD_W-1:0]  candidate;
   logic               accept;
   logic               unused_rand_hi;

   assign candidate      = rand_in[CARD_W-1:0];
   assign unused_rand_hi = ^rand_in[N-1:CARD_W];

   // NOTE: rand_en and busy decode the state register directly, so an async
   // reset drops the generator enable in the same cycle with no extra flop.
   assign rand_en = (state == SPIN);
   assign busy    = (state != IDLE);

   always_comb begin
      accept = (candidate != NO_CARD) && (candidate <= MAX_RANK);
`ifdef CARD_NO_REPEAT_EN
      if ((card != NO_CARD) && (candidate == card)) accept = 1'b0;
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         spin_cnt   <= '0;
         card       <= NO_CARD;
         prev_card  <= NO_CARD;
         has_prev   <= 1'b0;
         card_valid <= 1'b0;
         cmp_higher <= 1'b0;
         cmp_equal  <= 1'b0;
      end else begin
         card_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (draw_req) begin
                  state    <= SPIN;
                  spin_cnt <= '0;
               end
            end
            SPIN: begin
               if (spin_cnt == LAST_SPIN) state <= CHECK;
               else                       spin_cnt <= spin_cnt + 1'b1;
            end
            CHECK: begin
               if (accept) begin
                  prev_card  <= card;
                  card       <= candidate;
                  has_prev   <= (card != NO_CARD);
                  cmp_higher <= (candidate > card);
                  cmp_equal  <= (candidate == card);
                  card_valid <= 1'b1;
                  state      <= IDLE;
               end else begin
                  // A reject re-spins for exactly one generator step.
                  spin_cnt <= LAST_SPIN;
                  state    <= SPIN;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_card_dealer.sv
// Scoreboard bench for card_dealer with a scripted generator stub.
module tb_card_dealer;

   localparam int SPIN_MIN = 4;
   localparam int CARD_MAX = 13;

   logic       clk      = 1'b0;
   logic       reset    = 1'b1;
   logic       draw_req = 1'b0;
   logic [7:0] rand_in  = 8'h00;
   logic       rand_en, busy, has_prev, card_valid, cmp_higher, cmp_equal;
   logic [3:0] card, prev_card;

   typedef struct {
      int card;
      int prev;
      int has_prev;
      int higher;
      int equal;
      int busy_cyc;
      int en_cyc;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       mon_e;
   logic [7:0] rand_q[$];
   int         vectors = 0;
   int         errors  = 0;
   int         m_card  = 0;
   int         busy_cnt = 0;
   int         en_cnt   = 0;
   logic       last_valid = 1'b0;

   card_dealer #(.N(8), .CARD_MAX(CARD_MAX), .SPIN_MIN(SPIN_MIN)) dut (
      .clk        (clk),
      .reset      (reset),
      .draw_req   (draw_req),
      .rand_in    (rand_in),
      .rand_en    (rand_en),
      .busy       (busy),
      .card       (card),
      .prev_card  (prev_card),
      .has_prev   (has_prev),
      .card_valid (card_valid),
      .cmp_higher (cmp_higher),
      .cmp_equal  (cmp_equal)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int expv);
      vectors++;
      if (obs != expv) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
      end
   endtask

   // Generator stub: shows the head script word on every step, retires it
   // once the dealer has evaluated it (a CHECK cycle).
   always @(posedge clk) begin
      if (rand_en) begin
         if (rand_q.size() > 0) rand_in <= rand_q[0];
         else                   rand_in <= 8'h00;
      end else if (busy && rand_q.size() > 0) begin
         void'(rand_q.pop_front());
      end
   end

   // Scoreboard monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (reset) begin
         busy_cnt   = 0;
         en_cnt     = 0;
         last_valid = 1'b0;
      end else begin
         if (busy)    busy_cnt++;
         if (rand_en) en_cnt++;
         if (card_valid) begin
            if (last_valid) check("valid_pulse_width", 1, 0);
            if (exp_q.size() == 0) begin
               check("spurious_valid", 1, 0);
            end else begin
               mon_e = exp_q.pop_front();
               check("card",        card,      mon_e.card);
               check("prev_card",   prev_card, mon_e.prev);
               check("has_prev",    has_prev,  mon_e.has_prev);
               check("busy_cycles", busy_cnt,  mon_e.busy_cyc);
               check("rand_en_cyc", en_cnt,    mon_e.en_cyc);
               if (mon_e.has_prev != 0) begin
                  check("cmp_higher", cmp_higher, mon_e.higher);
                  check("cmp_equal",  cmp_equal,  mon_e.equal);
               end
            end
            busy_cnt = 0;
            en_cnt   = 0;
         end
         last_valid = card_valid;
      end
   end

   function automatic bit model_accept(input int c);
      if (c < 1 || c > CARD_MAX) return 1'b0;
`ifdef CARD_NO_REPEAT_EN
      if (m_card != 0 && c == m_card) return 1'b0;
`endif
      return 1'b1;
   endfunction

   // Queue generator words for one draw and the expected result.
   task automatic push_draw(input int n, input logic [7:0] w0,
                            input logic [7:0] w1 = 8'h00,
                            input logic [7:0] w2 = 8'h00);
      logic [7:0] w[3];
      int   rej = 0;
      int   c;
      exp_t e;
      w = '{w0, w1, w2};
      for (int i = 0; i < n; i++) begin
         c = int'(w[i][3:0]);
         rand_q.push_back(w[i]);
         if (model_accept(c)) begin
            e.card     = c;
            e.prev     = m_card;
            e.has_prev = (m_card != 0) ? 1 : 0;
            e.higher   = (c > m_card) ? 1 : 0;
            e.equal    = (c == m_card) ? 1 : 0;
            e.busy_cyc = SPIN_MIN + 1 + 2 * rej;
            e.en_cyc   = SPIN_MIN + rej;
            exp_q.push_back(e);
            m_card = c;
            return;
         end
         rej++;
      end
   endtask

   task automatic pulse_draw();
      @(negedge clk) draw_req = 1'b1;
      @(negedge clk) draw_req = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      int t = 0;
      while (exp_q.size() != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (exp_q.size() != 0) begin
         check({tag, "_timeout"}, exp_q.size(), 0);
         exp_q.delete();
      end
      repeat (3) @(negedge clk);
      check({tag, "_idle_busy"}, busy, 0);
      check({tag, "_script_used"}, rand_q.size(), 0);
   endtask

   initial begin
      int seen;
      repeat (2) @(negedge clk);
      check("rst_card",     card,       0);
      check("rst_prev",     prev_card,  0);
      check("rst_has_prev", has_prev,   0);
      check("rst_valid",    card_valid, 0);
      check("rst_busy",     busy,       0);
      check("rst_rand_en",  rand_en,    0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      push_draw(1, 8'h37);
      pulse_draw();
      wait_drain("first");

      push_draw(3, 8'h40, 8'h5E, 8'h29);
      pulse_draw();
      wait_drain("two_rejects");

      push_draw(2, 8'h09, 8'h03);
      pulse_draw();
      wait_drain("repeat");

      // Requests while busy are ignored.
      push_draw(1, 8'h21);
      @(negedge clk) draw_req = 1'b1;
      @(negedge clk) draw_req = 1'b0;
      @(negedge clk) draw_req = 1'b1;
      @(negedge clk) draw_req = 1'b0;
      @(negedge clk) draw_req = 1'b1;
      @(negedge clk) draw_req = 1'b0;
      wait_drain("busy_ignore");

      // Level held high: back-to-back draws, boundary candidates 0/F/E/D/1.
      push_draw(3, 8'hF0, 8'h1F, 8'h3D);
      push_draw(2, 8'hAE, 8'h51);
      seen = 0;
      @(negedge clk) draw_req = 1'b1;
      for (int t = 0; t < 100 && seen < 2; t++) begin
         @(negedge clk);
         if (card_valid) seen++;
      end
      draw_req = 1'b0;
      check("held_valid_count", seen, 2);
      wait_drain("held");

      // Async reset in SPIN abandons the draw.
      rand_q.push_back(8'h22);
      pulse_draw();
      @(negedge clk);
      check("spin_rand_en", rand_en, 1);
      #2 reset = 1'b1;
      #1;
      check("mid_rst_rand_en", rand_en,    0);
      check("mid_rst_busy",    busy,       0);
      check("mid_rst_card",    card,       0);
      check("mid_rst_prev",    prev_card,  0);
      check("mid_rst_hasprev", has_prev,   0);
      check("mid_rst_valid",   card_valid, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      rand_q.delete();
      m_card = 0;
      repeat (4) @(negedge clk);
      check("post_rst_card", card, 0);

      push_draw(1, 8'h15);
      pulse_draw();
      wait_drain("after_reset");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

endmodule
